mem_and_wb: RTL
===============

Name: mem_and_wb

Overview:
Memory-access and write-back stage, directly downstream of the combined ID/EX stage and its EX/MEM register.
- Consumes the EX/MEM outputs: control bits, ALU result, store data and destination register.
- Performs the data-memory load/store.
- Registers the write-back triple (regwrite, write_data, write_addr) that is fed back to the register file in the decode stage.
- After reset, clears the data memory with a small state machine and flags itself busy until the clear is done.

Parameters:
DMEM_DEPTH, 256, number of 8-bit data-memory words; power of 2, range 2..256.
DMEM_AW, 8, address width used; equals log2(DMEM_DEPTH); the address is alu_result_in[DMEM_AW-1:0].

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
regwrite_in  input  1  EX/MEM register-write enable.
mem_read_in  input  1  EX/MEM load enable.
mem_write_in  input  1  EX/MEM store enable.
mem_to_reg_in  input  1  1 = write back load data; 0 = write back ALU result.
alu_result_in  input  8  ALU result; also the data-memory address.
write_data_in  input  8  store data (rd register value).
rd_address_in  input  3  destination register index.
regwrite  output  1  MEM/WB register-write enable, to the register file.
write_data  output  8  MEM/WB write-back data.
write_addr  output  3  MEM/WB destination register.
mem_busy  output  1  high while the memory clear is in progress.
load_count  output  16  loads performed (see Optional Feature).
store_count  output  16  stores performed (see Optional Feature).

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - regwrite=0, write_data=8'h00, write_addr=3'd0, mem_busy=1.
  - load_count=0, store_count=0.
  - FSM goes to CLEAR with clear_ptr=0.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes 8'h00 to mem[clear_ptr], then clear_ptr += 1.
  - When clear_ptr == DMEM_DEPTH-1, the final word is written and the next state is RUN.
  - mem_busy=1 for exactly DMEM_DEPTH cycles after rst deasserts; it is 0 in the first RUN cycle.
  - All inputs are ignored: no stores; regwrite/write_data/write_addr held at 0.
- rst asserted in any state, including mid-CLEAR: CLEAR restarts at clear_ptr=0 on the next edge.
- RUN, store:
  - mem_write_in=1 writes write_data_in to mem[alu_result_in[DMEM_AW-1:0]] on the edge.
  - Upper address bits beyond DMEM_AW are ignored (wrap-around).
- RUN, load:
  - Read is combinational (asynchronous) from mem[addr].
  - A load in the cycle after a store to the same address returns the new data.
- Simultaneous mem_read_in and mem_write_in (never produced by the decoder): the store is performed; the read returns the pre-store value.
- MEM/WB register (RUN), updated every edge:
  - regwrite <= regwrite_in.
  - write_addr <= rd_address_in.
  - write_data <= mem_to_reg_in ? mem_rdata : alu_result_in.
  - Latency: 1 cycle from the EX/MEM outputs to the write-back outputs.
- mem_to_reg_in=1 with mem_read_in=0: memory is still read at addr (defined behaviour; no error).
- No stall or flush input. Upstream must not issue memory operations while mem_busy=1; any that arrive are dropped.

Optional Feature:
Macro: MEMWB_LDST_CNT_EN.
- Defined:
  - load_count increments on each RUN cycle with mem_read_in=1.
  - store_count increments on each RUN cycle with mem_write_in=1.
  - Both are 16-bit, saturate at 16'hFFFF, and are cleared by rst.
  - Neither counts during CLEAR.
  - When mem_read_in and mem_write_in are both 1, both counters increment.
- Not defined: load_count and store_count are tied to 16'h0000 and no counter flops are built.

Test Plan:
1. Reset then clear: pulse rst for 1 cycle with DMEM_DEPTH=256 -> mem_busy=1 for exactly 256 cycles then 0; regwrite=0 throughout; later loads from addresses 0x00, 0x7F, 0xFF return 8'h00.
2. Store then load: store 8'hA5 to addr 8'h10, next cycle load 8'h10 with mem_to_reg_in=1, rd=3'd5 -> one cycle later regwrite=1, write_addr=5, write_data=8'hA5.
3. ALU passthrough: regwrite_in=1, mem_to_reg_in=0, alu_result_in=8'h3C, rd=3'd2 -> next cycle write_data=8'h3C, write_addr=2; memory unchanged.
4. Mid-clear reset: assert rst at clear cycle 100, then release -> mem_busy stays high a further full 256 cycles; a store issued during busy is dropped, so a load of that address after busy returns 8'h00.
5. Address wrap with DMEM_DEPTH=16: store 8'h77 to addr 8'h13 -> load of addr 8'h03 returns 8'h77.
6. With MEMWB_LDST_CNT_EN: 3 loads, 2 stores, 1 load+store in the same cycle -> load_count=4, store_count=3; without the macro, both counters read 0.

Source files
------------

// File: rtl/mem_and_wb_if.sv
// EX/MEM-to-MEM/WB bus: EX/MEM control/data in, write-back triple, status and counters out.
interface mem_and_wb_if;
    logic        regwrite_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        mem_to_reg_in;
    logic [7:0]  alu_result_in;
    logic [7:0]  write_data_in;
    logic [2:0]  rd_address_in;
    logic        regwrite;
    logic [7:0]  write_data;
    logic [2:0]  write_addr;
    logic        mem_busy;
    logic [15:0] load_count;
    logic [15:0] store_count;

    modport master (
        output regwrite_in, mem_read_in, mem_write_in, mem_to_reg_in,
               alu_result_in, write_data_in, rd_address_in,
        input  regwrite, write_data, write_addr, mem_busy, load_count, store_count
    );

    modport slave (
        input  regwrite_in, mem_read_in, mem_write_in, mem_to_reg_in,
               alu_result_in, write_data_in, rd_address_in,
        output regwrite, write_data, write_addr, mem_busy, load_count, store_count
    );
endinterface

// File: rtl/mem_and_wb.sv
// Memory-access / write-back stage with post-reset data-memory clear.
// Optional load/store counters enabled by defining MEMWB_LDST_CNT_EN.
module mem_and_wb #(
    parameter int unsigned DMEM_DEPTH = 256,
    parameter int unsigned DMEM_AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_and_wb_if.slave   bus
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]         state, state_nxt;
    logic [DMEM_AW-1:0] clear_ptr, clear_ptr_nxt;
    logic               clear_last_c;
    logic [DMEM_AW-1:0] addr_c;
    logic [7:0]         mem_rdata_c;
    logic [7:0]         mem [DMEM_DEPTH];

    assign addr_c       = bus.alu_result_in[DMEM_AW-1:0];
    assign mem_rdata_c  = mem[addr_c];
    assign clear_last_c = (clear_ptr == DMEM_AW'(DMEM_DEPTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLEAR;
            clear_ptr <= '0;
        end else begin
            state     <= state_nxt;
            clear_ptr <= clear_ptr_nxt;
        end
    end

    // Next-state logic: sweep the memory once, then run
    always_comb begin
        state_nxt     = state;
        clear_ptr_nxt = clear_ptr;
        case (state)
            S_CLEAR: begin
                clear_ptr_nxt = clear_ptr + 1'b1;
                if (clear_last_c) state_nxt = S_RUN;
            end
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // Data memory: clear sweep owns the write port until RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR)
                mem[clear_ptr] <= 8'h00;
            else if (bus.mem_write_in)
                mem[addr_c] <= bus.write_data_in;
        end
    end

    // MEM/WB register and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.regwrite   <= 1'b0;
            bus.write_data <= 8'h00;
            bus.write_addr <= 3'd0;
            bus.mem_busy   <= 1'b1;
        end else if (state == S_CLEAR) begin
            bus.regwrite   <= 1'b0;
            bus.write_data <= 8'h00;
            bus.write_addr <= 3'd0;
            bus.mem_busy   <= !clear_last_c;
        end else begin
            bus.regwrite   <= bus.regwrite_in;
            bus.write_addr <= bus.rd_address_in;
            bus.write_data <= bus.mem_to_reg_in ? mem_rdata_c : bus.alu_result_in;
            bus.mem_busy   <= 1'b0;
        end
    end

`ifdef MEMWB_LDST_CNT_EN
    // Saturating load/store counters, RUN only
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.load_count  <= 16'h0000;
            bus.store_count <= 16'h0000;
        end else if (state == S_RUN) begin
            if (bus.mem_read_in && (bus.load_count != 16'hFFFF))
                bus.load_count <= bus.load_count + 16'd1;
            if (bus.mem_write_in && (bus.store_count != 16'hFFFF))
                bus.store_count <= bus.store_count + 16'd1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok       = &{1'b0, bus.mem_read_in};
    assign bus.load_count  = 16'h0000;
    assign bus.store_count = 16'h0000;
`endif

endmodule
